instr_encoder: RTL and testbench
================================

# instr_encoder

Field-level RISC-V instruction encoder with an output buffer, the inverse of the core's instruction decoder. It accepts one instruction per handshake as separate fields (opcode, rd, rs1, rs2, funct3, funct7, immediate), packs them into a 32-bit RV32 word, and streams the words with sequential addresses toward instruction memory. It is used for program loading and for self-checking benches that round-trip words through the decoder.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `BASE_ADDR`, 32'h0000_0000: address of the first emitted word.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `clear`  in  1  synchronous flush: empty FIFO, rewind address, clear flags.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  encoder can accept.
- `in_opcode`  in  7  opcode.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register fields.
- `in_funct3`  in  3,  `in_funct7`  in  7.
- `in_imm`  in  32  signed immediate, byte offset for B/J, full value for U.
- `out_valid`  out  1  head word present.
- `out_ready`  in  1  consumer takes head word.
- `out_instr`  out  32  encoded word; 0 when empty.
- `out_addr`  out  32  address of head word.
- `imm_err`  out  1  sticky: an immediate was out of range or misaligned.
- `illegal_op`  out  1  sticky: an unsupported opcode was rejected.

## Operation
- Type by opcode: R = ALU 0110011; I = LOAD 0000011, ALU_IMM 0010011; S = STORE 0100011; B = BRANCH 1100011; J = JAL 1101111; U = LUI 0110111, AUIPC 0010111. `OPCODE_NOP` is encoded as I-type using the supplied fields.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Fields not used by the type are ignored.
- Range checks:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - On violation the word is still encoded (bits truncated as packed) and enqueued, and `imm_err` is set.
- Unknown opcode: the request is accepted (handshake completes), nothing is enqueued, and `illegal_op` is set.
- Address counter: starts at `BASE_ADDR` and adds 4 (mod 2^32) on every output handshake. `out_addr` always shows the counter.
- Flags stay set until `reset` or `clear`.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=`BASE_ADDR`, `imm_err`=0, `illegal_op`=0, FIFO empty.
- `in_ready` = (count < DEPTH) && !reset && !clear. It is combinational from state and is low during any reset or clear cycle.
- Latency: a word accepted at edge N is at the FIFO head (`out_valid`=1) after edge N if the FIFO was empty.
- Full FIFO: `in_ready`=0; there is no same-cycle pass-through, so a pop frees a slot for the next cycle only.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and order is preserved.
- Flags set on the accepting edge and are visible the next cycle.
- `clear` or `reset` mid-stream: all buffered words are discarded, and any handshake in that cycle is ignored. `clear` and `reset` are identical in effect.
- `out_valid`, `out_instr` and `out_addr` hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `riscv_pkg`: opcode constants, instruction-type enum, immediate range limits. The same package is reused by the decoder.
- Sub-module `sync_fifo` (parameterised width/depth, synchronous active-high reset plus `clear`).
- The encode/check logic is a function in the package so the bench can reuse it.

## Test plan
- Single words, out_ready=1: addi x1,x0,5 → 0x00500093 @0x0; add x3,x1,x2 → 0x002081B3 @0x4; sw x2,8(x1) → 0x0020A423 @0x8; beq x1,x2,+8 → 0x00208463 @0xC.
- lui x5 with imm 0x12345000 → 0x123452B7; jal x1 with imm 2048 → 0x001000EF. Both flags stay 0.
- DEPTH=4, out_ready=0, 5 back-to-back requests: `in_ready` drops after the 4th. Then release out_ready: 4 words emerge in order at 0x0,0x4,0x8,0xC, and the 5th is accepted one cycle after the first pop.
- addi x1,x0 with imm 4096 → word 0x00000093 enqueued and `imm_err`=1. beq with imm 3 → `imm_err`=1.
- opcode 0x7F → handshake completes, no word emitted, `illegal_op`=1, address counter unchanged.
- 3 words buffered, assert `clear` for one cycle → next cycle `out_valid`=0, `out_addr`=`BASE_ADDR`, flags 0. A following addi appears at `BASE_ADDR`.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  riscv_pkg
//  Shared RV32 opcode constants, instruction-type enum, immediate range limits
//  and the field-level encode/check function used by the encoder.
//  Revision: 1.0
// ============================================================================
package riscv_pkg;

  // Base opcodes
  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  // NOP is the canonical addi x0,x0,0, so it shares the ALU_IMM opcode
  localparam logic [6:0] OPCODE_NOP     = OPCODE_ALU_IMM;

  // Signed immediate limits per format
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX =  32'sd4094;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX =  32'sd1048574;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_BAD = 3'd6
  } instr_type_e;

  typedef struct packed {
    logic [31:0] word;
    logic        imm_err;
    logic        illegal;
  } enc_t;

  // Map an opcode onto its instruction format
  function automatic instr_type_e op_type(input logic [6:0] op);
    instr_type_e t;
    case (op)
      OPCODE_ALU:                   t = TYPE_R;
      OPCODE_LOAD, OPCODE_ALU_IMM:  t = TYPE_I;
      OPCODE_STORE:                 t = TYPE_S;
      OPCODE_BRANCH:                t = TYPE_B;
      OPCODE_JAL:                   t = TYPE_J;
      OPCODE_LUI, OPCODE_AUIPC:     t = TYPE_U;
      default:                      t = TYPE_BAD;
    endcase
    return t;
  endfunction

  // Pack fields into a 32-bit word and flag bad immediates / opcodes.
  // Out-of-range immediates are still packed (truncated) so the caller
  // can enqueue the word while raising the error flag.
  function automatic enc_t encode_instr(
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    enc_t             r;
    logic signed [31:0] s;
    s = $signed(imm);
    r = '0;
    case (op_type(op))
      TYPE_R: r.word = {f7, rs2, rs1, f3, rd, op};
      TYPE_I: begin
        r.word    = {imm[11:0], rs1, f3, rd, op};
        r.imm_err = (s < IMM12_MIN) || (s > IMM12_MAX);
      end
      TYPE_S: begin
        r.word    = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        r.imm_err = (s < IMM12_MIN) || (s > IMM12_MAX);
      end
      TYPE_B: begin
        r.word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        r.imm_err = (s < IMM13_MIN) || (s > IMM13_MAX) || imm[0];
      end
      TYPE_U: begin
        r.word    = {imm[31:12], rd, op};
        r.imm_err = (imm[11:0] != 12'd0);
      end
      TYPE_J: begin
        r.word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        r.imm_err = (s < IMM21_MIN) || (s > IMM21_MAX) || imm[0];
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  sync_fifo
//  Single-clock FIFO, power-of-two depth, synchronous reset and clear.
//  Read data is 0 while empty; no write-to-read bypass.
//  Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset and clear both discard contents
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  instr_encoder
//  Packs RV32 instruction fields into 32-bit words, buffers them in a FIFO
//  and streams them out with sequential addresses. Sticky flags report bad
//  immediates and rejected opcodes.
//  Revision: 1.0
// ============================================================================
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        imm_err,
  output logic        illegal_op
);

  enc_t        enc;
  logic        accept, push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] addr_q, addr_d;
  logic        imm_err_q, imm_err_d;
  logic        illegal_q, illegal_d;

  // Encode the presented request every cycle
  always_comb begin
    enc = encode_instr(in_opcode, in_rd, in_rs1, in_rs2,
                       in_funct3, in_funct7, in_imm);
  end

  assign in_ready = !fifo_full && !reset && !clear;
  assign accept   = in_valid && in_ready;
  // Illegal opcodes complete the handshake but never reach the buffer
  assign push     = accept && !enc.illegal;
  assign pop      = !fifo_empty && out_ready && !reset && !clear;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (enc.word),
    .rdata (out_instr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state for the address counter and the sticky flags
  always_comb begin
    addr_d    = addr_q;
    imm_err_d = imm_err_q;
    illegal_d = illegal_q;
    if (pop)                    addr_d    = addr_q + 32'd4;
    if (accept && enc.imm_err)  imm_err_d = 1'b1;
    if (accept && enc.illegal)  illegal_d = 1'b1;
  end

  // Address counter and flag registers; clear behaves exactly like reset
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      addr_q    <= BASE_ADDR;
      imm_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      imm_err_q <= imm_err_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_addr   = addr_q;
  assign imm_err    = imm_err_q;
  assign illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  tb_instr_encoder
//  Directed and randomized checks of instr_encoder against a queue-based
//  reference model computed with plain arithmetic.
//  Revision: 1.0
// ============================================================================
module tb_instr_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        imm_err, illegal_op;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [31:0] m_addr;
  bit          m_err, m_ill;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .imm_err    (imm_err),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Reference encoder: bit fields extracted with shifts and masks
  function automatic void model_enc(
    input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
    input int imm, output logic [31:0] w, output bit err, output bit ill);
    logic [31:0] u;
    logic [31:0] regs;
    u    = imm;
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    w = 0; err = 0; ill = 0;
    case (op)
      7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
      7'h03, 7'h13: begin
        w   = ((u & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'(op);
        err = (imm < -2048) || (imm > 2047);
      end
      7'h23: begin
        w   = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
              | ((u & 32'h1F) << 7) | 32'(op);
        err = (imm < -2048) || (imm > 2047);
      end
      7'h63: begin
        w   = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
              | regs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'(op);
        err = (imm < -4096) || (imm > 4094) || ((u & 1) != 0);
      end
      7'h6F: begin
        w   = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
              | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
              | (32'(rd) << 7) | 32'(op);
        err = (imm < -1048576) || (imm > 1048574) || ((u & 1) != 0);
      end
      7'h37, 7'h17: begin
        w   = (u & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
        err = (u & 32'hFFF) != 0;
      end
      default: ill = 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_valid = 1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One clock cycle: compare DUT to model, advance model, move to next negedge
  task automatic step();
    logic [31:0] w;
    bit e, il, m_rdy, m_pop;
    #1;
    m_rdy = (mq.size() < DEPTH) && !reset && !clear;
    chk("in_ready",  32'(in_ready),  32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_instr", out_instr, (mq.size() > 0) ? mq[0] : 32'h0);
    chk("out_addr",  out_addr,  m_addr);
    chk("imm_err",   32'(imm_err),    32'(m_err));
    chk("illegal",   32'(illegal_op), 32'(m_ill));
    m_pop = (mq.size() > 0) && out_ready;
    if (reset || clear) begin
      mq.delete(); m_addr = BASE_ADDR; m_err = 0; m_ill = 0;
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (in_valid && m_rdy) begin
        model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
                  int'(in_imm), w, e, il);
        if (!il) mq.push_back(w);
        if (e)   m_err = 1;
        if (il)  m_ill = 1;
      end
    end
    @(negedge clk);
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63,
                           7'h6F, 7'h37, 7'h17, 7'h7F, 7'h00};

  initial begin
    reset = 1; clear = 0; in_valid = 0; out_ready = 0;
    req(0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    mq.delete(); m_addr = BASE_ADDR; m_err = 0; m_ill = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();                                   // reset state, in_ready low in reset
    reset = 0;
    chk("rst_addr",  out_addr, BASE_ADDR);
    chk("rst_instr", out_instr, 32'h0);

    // single words with out_ready=1
    out_ready = 1;
    req(7'h13, 1, 0, 0, 0, 0, 5);             step();
    chk("addi_word", out_instr, 32'h00500093); chk("addi_addr", out_addr, 32'h0);
    req(7'h33, 3, 1, 2, 0, 0, 0);             step();
    chk("add_word", out_instr, 32'h002081B3);  chk("add_addr", out_addr, 32'h4);
    req(7'h23, 0, 1, 2, 2, 0, 8);             step();
    chk("sw_word", out_instr, 32'h0020A423);   chk("sw_addr", out_addr, 32'h8);
    req(7'h63, 0, 1, 2, 0, 0, 8);             step();
    chk("beq_word", out_instr, 32'h00208463);  chk("beq_addr", out_addr, 32'hC);
    req(7'h37, 5, 0, 0, 0, 0, 32'h12345000);  step();
    chk("lui_word", out_instr, 32'h123452B7);
    req(7'h6F, 1, 0, 0, 0, 0, 2048);          step();
    chk("jal_word", out_instr, 32'h001000EF);
    chk("flags_ok", {30'd0, imm_err, illegal_op}, 32'h0);
    in_valid = 0;                             step();

    // back-pressure: fill the FIFO and check in-order drain
    clear = 1;                                step();
    clear = 0; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      req(7'h13, 5'(i + 1), 0, 0, 0, 0, 32'(i));
      step();
    end
    req(7'h13, 5, 0, 0, 0, 0, 4);             // 5th request held
    #1 chk("full_ready", 32'(in_ready), 32'h0);
    step();
    out_ready = 1;
    chk("bp_first_addr", out_addr, 32'h0);
    step();                                   // first pop, 5th not yet taken
    #1 chk("ready_after_pop", 32'(in_ready), 32'h1);
    step();                                   // 5th accepted here
    in_valid = 0;
    repeat (5) step();
    chk("bp_final_addr", out_addr, 32'h14);

    // immediate errors
    clear = 1;                                step();
    clear = 0;
    req(7'h13, 1, 0, 0, 0, 0, 4096);          step();
    in_valid = 0;
    chk("bigimm_word", out_instr, 32'h00000093);
    chk("bigimm_err", 32'(imm_err), 32'h1);
    step();
    clear = 1;                                step();
    clear = 0;
    req(7'h63, 0, 1, 2, 0, 0, 3);             step();
    in_valid = 0;
    chk("beq_odd_err", 32'(imm_err), 32'h1);
    step();

    // unsupported opcode
    clear = 1;                                step();
    clear = 0;
    req(7'h7F, 1, 2, 3, 0, 0, 0);             step();
    in_valid = 0;
    chk("illegal_flag", 32'(illegal_op), 32'h1);
    chk("illegal_noword", 32'(out_valid), 32'h0);
    chk("illegal_addr", out_addr, BASE_ADDR);
    step();

    // clear with three buffered words and a pending handshake
    clear = 1;                                step();
    clear = 0; out_ready = 0;
    req(7'h13, 1, 0, 0, 0, 0, 1);             step();
    req(7'h13, 2, 0, 0, 0, 0, 5000);          step();
    req(7'h13, 3, 0, 0, 0, 0, 3);             step();
    clear = 1; out_ready = 1;                 step();
    clear = 0; in_valid = 0;
    chk("clr_valid", 32'(out_valid), 32'h0);
    chk("clr_addr", out_addr, BASE_ADDR);
    chk("clr_flags", {30'd0, imm_err, illegal_op}, 32'h0);
    req(7'h13, 1, 0, 0, 0, 0, 5);             step();
    in_valid = 0;
    chk("post_clr_addr", out_addr, BASE_ADDR);
    chk("post_clr_word", out_instr, 32'h00500093);
    step();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      int imm_r;
      case ($urandom_range(0, 3))
        0:       imm_r = int'($urandom_range(0, 4200)) - 2100;
        1:       imm_r = int'($urandom_range(0, 9000)) - 4500;
        2:       imm_r = int'($urandom) & 32'hFFFF_F000;
        default: imm_r = int'($urandom);
      endcase
      req(ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), 32'(imm_r));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 0; clear = 0; in_valid = 0; out_ready = 1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
